// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port with fixed-latency read return tagging.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate priority after every grant (default: requester 1 always wins).
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_req,
  input  logic [DATA_W/8-1:0] r0_we,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [DATA_W-1:0]   r0_wdata,
  input  logic                r1_req,
  input  logic [DATA_W/8-1:0] r1_we,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [DATA_W-1:0]   r1_wdata,
  output logic                r0_gnt,
  output logic                r1_gnt,
  output logic                r0_rvalid,
  output logic                r1_rvalid,
  output logic [DATA_W-1:0]   r0_rdata,
  output logic [DATA_W-1:0]   r1_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout,
  input  logic                mem_accept_rd,
  input  logic                mem_accept_wr,
  output logic [3:0]          rd_pending
);

  localparam int BE_W = DATA_W / 8;

  logic                elig0, elig1, r1_win, rd_issue;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic [READ_LAT-1:0] tag_v, tag_id;
  logic [3:0]          pend_q;

  assign elig0 = r0_req && ((r0_we == '0) ? mem_accept_rd : mem_accept_wr);
  assign elig1 = r1_req && ((r1_we == '0) ? mem_accept_rd : mem_accept_wr);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic prio_r0;  // 1: requester 0 wins a tie
  assign r1_win = elig1 && !(elig0 && prio_r0);
`else
  assign r1_win = elig1;
`endif

  assign r1_gnt = !rst && r1_win;
  assign r0_gnt = !rst && elig0 && !r1_win;

  assign mem_en   = r0_gnt || r1_gnt;
  assign mem_we   = r1_gnt ? r1_we : (r0_gnt ? r0_we : {BE_W{1'b0}});
  assign mem_addr = rst ? '0 : (r1_gnt ? r1_addr : (r0_gnt ? r0_addr : addr_q));
  assign mem_din  = rst ? '0 : (r1_gnt ? r1_wdata : (r0_gnt ? r0_wdata : din_q));
  assign rd_issue = mem_en && (mem_we == '0);

  // Oldest tag sits in the top stage; its data is on mem_dout this cycle.
  assign r1_rvalid  = !rst && tag_v[READ_LAT-1] && tag_id[READ_LAT-1];
  assign r0_rvalid  = !rst && tag_v[READ_LAT-1] && !tag_id[READ_LAT-1];
  assign r0_rdata   = mem_dout;
  assign r1_rdata   = mem_dout;
  assign rd_pending = rst ? 4'd0 : pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v   <= '0;
      tag_id  <= '0;
      pend_q  <= 4'd0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_r0 <= 1'b0;
`endif
    end else begin
      for (int i = READ_LAT - 1; i > 0; i--) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      tag_v[0]  <= rd_issue;
      tag_id[0] <= r1_gnt;
      case ({rd_issue, tag_v[READ_LAT-1]})
        2'b10:   pend_q <= pend_q + 4'd1;
        2'b01:   pend_q <= pend_q - 4'd1;
        default: pend_q <= pend_q;
      endcase
      if (mem_en) begin
        addr_q  <= mem_addr;
        din_q   <= mem_din;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prio_r0 <= r1_gnt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_req = 1'b0, r1_req = 1'b0;
  logic [BW-1:0] r0_we = '0, r1_we = '0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          mem_accept_rd = 1'b0, mem_accept_wr = 1'b0;
  logic [3:0]    rd_pending;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_accept_rd(mem_accept_rd), .mem_accept_wr(mem_accept_wr),
    .rd_pending(rd_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {bit id; int issue;} rd_t;
  rd_t q[$];

  // Monitor: read returns and outstanding-read count, from the scoreboard queue.
  always @(negedge clk) begin
    int exp_pend;
    rd_t e;
    if (rst) begin
      chk("rvalid0_rst", r0_rvalid, 0);
      chk("rvalid1_rst", r1_rvalid, 0);
      chk("pending_rst", rd_pending, 0);
    end else begin
      exp_pend = 0;
      foreach (q[i]) if (q[i].issue < cyc) exp_pend++;
      chk("rd_pending", rd_pending, exp_pend);
      chk("pending_bound", (rd_pending <= L), 1);
      if (q.size() > 0 && q[0].issue + L == cyc) begin
        e = q.pop_front();
        chk("r0_rvalid", r0_rvalid, e.id == 1'b0);
        chk("r1_rvalid", r1_rvalid, e.id == 1'b1);
        chk("rdata", e.id ? r1_rdata : r0_rdata, mem_dout);
      end else begin
        chk("r0_rvalid_idle", r0_rvalid, 0);
        chk("r1_rvalid_idle", r1_rvalid, 0);
      end
    end
  end

  initial begin
    bit            act0, act1, e0, e1, fav1;
    int            w, load;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_din;
    rd_t           ne;
    act0 = 0; act1 = 0; fav1 = 1; last_addr = '0; last_din = '0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      load = (n < 1000) ? 95 : ((n < 2000) ? 60 : 25);
      rst = (n < 3) || ($urandom_range(0, 149) == 0);
      if (!act0 || $urandom_range(0, 9) == 0) begin
        act0 = ($urandom_range(0, 99) < load);
        r0_req = act0;
        r0_we = $urandom_range(0, 1) ? BW'($urandom) : '0;
        r0_addr = $urandom; r0_wdata = $urandom;
      end
      if (!act1 || $urandom_range(0, 9) == 0) begin
        act1 = ($urandom_range(0, 99) < load);
        r1_req = act1;
        r1_we = $urandom_range(0, 1) ? BW'($urandom) : '0;
        r1_addr = $urandom; r1_wdata = $urandom;
      end
      mem_accept_rd = ($urandom_range(0, 9) < 8);
      mem_accept_wr = ($urandom_range(0, 9) < 7);
      mem_dout = $urandom;
      @(negedge clk);
      if (rst) begin
        chk("r0_gnt_rst", r0_gnt, 0);
        chk("r1_gnt_rst", r1_gnt, 0);
        chk("mem_en_rst", mem_en, 0);
        chk("mem_we_rst", mem_we, 0);
        chk("mem_addr_rst", mem_addr, 0);
        chk("mem_din_rst", mem_din, 0);
        fav1 = 1; last_addr = '0; last_din = '0;
        q.delete();
      end else begin
        e0 = r0_req && ((r0_we == '0) ? mem_accept_rd : mem_accept_wr);
        e1 = r1_req && ((r1_we == '0) ? mem_accept_rd : mem_accept_wr);
        w = -1;
        if (e0 && e1) w = fav1 ? 1 : 0;
        else if (e1) w = 1;
        else if (e0) w = 0;
        chk("r0_gnt", r0_gnt, w == 0);
        chk("r1_gnt", r1_gnt, w == 1);
        chk("mem_en", mem_en, w >= 0);
        if (w < 0) begin
          chk("mem_we_idle", mem_we, 0);
          chk("mem_addr_hold", mem_addr, last_addr);
          chk("mem_din_hold", mem_din, last_din);
        end else begin
          last_addr = (w == 1) ? r1_addr : r0_addr;
          last_din  = (w == 1) ? r1_wdata : r0_wdata;
          chk("mem_we", mem_we, (w == 1) ? r1_we : r0_we);
          chk("mem_addr", mem_addr, last_addr);
          chk("mem_din", mem_din, last_din);
          if (((w == 1) ? r1_we : r0_we) == '0) begin
            ne.id = (w == 1); ne.issue = cyc;
            q.push_back(ne);
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          fav1 = (w == 0);
`endif
          if (w == 1) act1 = 0; else act0 = 0;
        end
      end
    end
    @(posedge clk); #1;
    rst = 0; r0_req = 0; r1_req = 0;
    repeat (L + 2) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
    chk("drain_pending", rd_pending, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of requesters and memory port.
REQ-002 Parameter: DATA_W, 32, data width; byte-enable width = DATA_W/8.
REQ-003 Parameter: READ_LAT, 3, fixed cycles from read issue to valid mem_dout; legal range 1..8.
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: r0_req / r1_req  in  1 each  request valid, requester 0 (fetch) / 1 (load-store).
REQ-007 Port: r0_we / r1_we  in  DATA_W/8 each  byte write enables; all-zero means read.
REQ-008 Port: r0_addr / r1_addr  in  ADDR_W each  request address.
REQ-009 Port: r0_wdata / r1_wdata  in  DATA_W each  write data.
REQ-010 Port: r0_gnt / r1_gnt  out  1 each  request issued to memory this cycle.
REQ-011 Port: r0_rvalid / r1_rvalid  out  1 each  read data for that requester valid this cycle.
REQ-012 Port: r0_rdata / r1_rdata  out  DATA_W each  read data, both driven from mem_dout.
REQ-013 Port: mem_en  out  1  memory port enable.
REQ-014 Port: mem_we  out  DATA_W/8  memory byte write enables.
REQ-015 Port: mem_addr  out  ADDR_W  memory address.
REQ-016 Port: mem_din  out  DATA_W  memory write data.
REQ-017 Port: mem_dout  in  DATA_W  memory read data.
REQ-018 Port: mem_accept_rd / mem_accept_wr  in  1 each  memory can take a read / write this cycle.
REQ-019 Port: rd_pending  out  4  count of issued reads not yet returned.

Function
REQ-020 Request eligible iff req=1 and (we==0 ? mem_accept_rd : mem_accept_wr).
REQ-021 At most one gnt per cycle; gnt combinational from eligibility and registered priority state.
REQ-022 Default arbitration: fixed priority, requester 1 over requester 0.
REQ-023 On gnt: mem_en=1, mem_we/mem_addr/mem_din = granted requester's inputs, same cycle.
REQ-024 No gnt: mem_en=0, mem_we=0; mem_addr/mem_din hold last issued value.
REQ-025 Requester holds req, we, addr, wdata stable until gnt; dropping req before gnt is legal, no effect.
REQ-026 Write: gnt is the only completion; no rvalid produced.
REQ-027 Read issue pushes {valid=1, id} into a READ_LAT-deep tag shift register; non-read cycles push valid=0.
REQ-028 rK_rvalid=1 exactly READ_LAT cycles after rK read gnt, for one cycle; other requester's rvalid=0.
REQ-029 Back-to-back reads (one per cycle, either requester) return in issue order, one per cycle, none dropped.
REQ-030 rd_pending: +1 on read issue, -1 on tag exit; simultaneous issue and exit leaves it unchanged; never exceeds READ_LAT.
REQ-031 Reads and writes are in order at the port; no address-hazard checking or forwarding.

Reset
REQ-032 While rst=1: all gnt=0, all rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, rd_pending=0; requests ignored.
REQ-033 Reset clears all tag stages; memory data for reads in flight at reset is discarded, no rvalid.
REQ-034 First gnt possible in the first cycle with rst=0; priority state resets to requester 1 highest.

Configuration
REQ-035 Macro MEM_ARB_ROUND_ROBIN_EN defined: priority pointer flips to the other requester after every gnt; simultaneous eligible requests alternate.
REQ-036 Macro undefined: fixed priority per REQ-022; no pointer register.

Verification
REQ-037 r0 read addr 0x10 alone, accepts high -> r0_gnt same cycle, r0_rvalid 3 cycles later with mem_dout, r1_rvalid=0.
REQ-038 r0 and r1 reads held 3 cycles, fixed priority -> gnt r1,r1,r1; r0 never granted; with RR macro -> r1,r0,r1.
REQ-039 r1 write we=4'b1111 addr 0x20 data 0xDEADBEEF, mem_accept_wr=0 for 2 cycles -> gnt 0 for 2 cycles, then gnt with mem_we=4'hF, no rvalid.
REQ-040 Alternating r0/r1 reads every cycle for 6 cycles -> rvalid sequence matches issue order delayed 3, rd_pending saturates at 3.
REQ-041 rst asserted 1 cycle after two reads issued -> no rvalid ever appears for them, rd_pending=0 after reset.
